// File: rtl/game_stage_ctrl.sv
// game_stage_ctrl
//   Turn and stage sequencer for a multi-seat betting game. A game runs
//   NUM_STAGES betting stages. In each stage every seat still in the hand
//   must act once, either by checking/betting or by folding. A seat that stays
//   idle for TIMEOUT_CYCLES cycles is folded automatically. The game ends when
//   the last stage completes, or as soon as only one seat remains.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   synchronous, active-high; highest priority
//   start        in   begin a game (honoured only in IDLE)
//   act_valid    in   the seat indicated by turn has acted this cycle (PLAY only)
//   act_fold     in   qualifies act_valid: 1 = fold, 0 = check/bet
//   reset_game   in   abort the game and return to IDLE
//   stage        out  current stage, 0 = no game
//   turn         out  seat index to act
//   active_mask  out  1 = seat still in the hand
//   stage_adv    out  one-cycle pulse when stage increments
//   timeout_fold out  one-cycle pulse when a seat is auto-folded
//   game_over    out  high while in DONE
//   winner_valid out  game ended with exactly one active seat
//   winner       out  index of the sole remaining seat
module game_stage_ctrl #(
    parameter int NUM_STAGES     = 5,
    parameter int NUM_PLAYERS    = 4,
    parameter int TIMEOUT_CYCLES = 1000,
    localparam int SW  = $clog2(NUM_STAGES + 1),
    localparam int TW  = ($clog2(NUM_PLAYERS) > 1) ? $clog2(NUM_PLAYERS) : 1,
    localparam int TMW = $clog2(TIMEOUT_CYCLES)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   act_valid,
    input  logic                   act_fold,
    input  logic                   reset_game,
    output logic [SW-1:0]          stage,
    output logic [TW-1:0]          turn,
    output logic [NUM_PLAYERS-1:0] active_mask,
    output logic                   stage_adv,
    output logic                   timeout_fold,
    output logic                   game_over,
    output logic                   winner_valid,
    output logic [TW-1:0]          winner
);

    typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;

    state_t                 state_q, state_d;
    logic [SW-1:0]          stage_q, stage_d;
    logic [TW-1:0]          turn_q, turn_d;
    logic [NUM_PLAYERS-1:0] active_q, active_d;
    logic [NUM_PLAYERS-1:0] acted_q, acted_d;
    logic [TMW-1:0]         timer_q, timer_d;
    logic                   stage_adv_q, stage_adv_d;
    logic                   timeout_fold_q, timeout_fold_d;
    logic                   game_over_q, game_over_d;
    logic                   winner_valid_q, winner_valid_d;
    logic [TW-1:0]          winner_q, winner_d;

    // Action evaluation: what the masks would look like if the current seat
    // acts (or times out) this cycle. The FSM decides whether to use it.
    logic                   timeout_hit;
    logic                   fold_eff;
    logic [NUM_PLAYERS-1:0] act_active;
    logic [NUM_PLAYERS-1:0] act_acted;
    logic [NUM_PLAYERS-1:0] pending;
    logic                   single_left;
    logic [TW-1:0]          low_idx;
    logic                   low_found;
    logic [TW-1:0]          nxt_idx;
    logic                   nxt_found;

    always_comb begin
        timeout_hit = !act_valid && (timer_q == TMW'(TIMEOUT_CYCLES - 1));
        fold_eff    = act_valid ? act_fold : 1'b1;
        act_active  = active_q;
        act_acted   = acted_q;
        if (fold_eff) begin
            act_active[turn_q] = 1'b0;
        end
        act_acted[turn_q] = 1'b1;
        pending     = act_active & ~act_acted;
        // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
        single_left = (act_active != '0) &&
                      ((act_active & (act_active - NUM_PLAYERS'(1))) == '0);

        low_idx   = '0;
        low_found = 1'b0;
        for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
            if (act_active[i[TW-1:0]] && !low_found) begin
                low_idx   = i[TW-1:0];
                low_found = 1'b1;
            end
        end

        // Search upward from the current seat, wrapping, for the first seat
        // still in the hand that has not acted this stage.
        nxt_idx   = turn_q;
        nxt_found = 1'b0;
        for (int unsigned k = 1; k < NUM_PLAYERS; k++) begin
            int unsigned j;
            j = int'(turn_q) + k;
            if (j >= NUM_PLAYERS) begin
                j = j - NUM_PLAYERS;
            end
            if (pending[j[TW-1:0]] && !nxt_found) begin
                nxt_idx   = j[TW-1:0];
                nxt_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        stage_d        = stage_q;
        turn_d         = turn_q;
        active_d       = active_q;
        acted_d        = acted_q;
        timer_d        = timer_q;
        stage_adv_d    = 1'b0;
        timeout_fold_d = 1'b0;
        winner_valid_d = winner_valid_q;
        winner_d       = winner_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = PLAY;
                    stage_d  = SW'(1);
                    turn_d   = '0;
                    active_d = '1;
                    acted_d  = '0;
                    timer_d  = '0;
                end
            end
            PLAY: begin
                if (act_valid || timeout_hit) begin
                    timer_d        = '0;
                    timeout_fold_d = timeout_hit;
                    active_d       = act_active;
                    acted_d        = act_acted;
                    if (single_left) begin
                        state_d        = DONE;
                        winner_valid_d = 1'b1;
                        winner_d       = low_idx;
                    end else if (pending == '0) begin
                        if (stage_q < SW'(NUM_STAGES)) begin
                            stage_d     = stage_q + SW'(1);
                            acted_d     = '0;
                            turn_d      = low_idx;
                            stage_adv_d = 1'b1;
                        end else begin
                            state_d = DONE;
                        end
                    end else begin
                        turn_d = nxt_idx;
                    end
                end else begin
                    timer_d = timer_q + TMW'(1);
                end
            end
            DONE: begin
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (reset_game) begin
            state_d        = IDLE;
            stage_d        = '0;
            turn_d         = '0;
            active_d       = '1;
            acted_d        = '0;
            timer_d        = '0;
            stage_adv_d    = 1'b0;
            timeout_fold_d = 1'b0;
            winner_valid_d = 1'b0;
            winner_d       = '0;
        end

        game_over_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            stage_q        <= '0;
            turn_q         <= '0;
            active_q       <= '1;
            acted_q        <= '0;
            timer_q        <= '0;
            stage_adv_q    <= 1'b0;
            timeout_fold_q <= 1'b0;
            game_over_q    <= 1'b0;
            winner_valid_q <= 1'b0;
            winner_q       <= '0;
        end else begin
            state_q        <= state_d;
            stage_q        <= stage_d;
            turn_q         <= turn_d;
            active_q       <= active_d;
            acted_q        <= acted_d;
            timer_q        <= timer_d;
            stage_adv_q    <= stage_adv_d;
            timeout_fold_q <= timeout_fold_d;
            game_over_q    <= game_over_d;
            winner_valid_q <= winner_valid_d;
            winner_q       <= winner_d;
        end
    end

    assign stage        = stage_q;
    assign turn         = turn_q;
    assign active_mask  = active_q;
    assign stage_adv    = stage_adv_q;
    assign timeout_fold = timeout_fold_q;
    assign game_over    = game_over_q;
    assign winner_valid = winner_valid_q;
    assign winner       = winner_q;

endmodule

// File: tb/tb_game_stage_ctrl.sv
// tb_game_stage_ctrl
//   Directed bench for game_stage_ctrl with NUM_STAGES=5, NUM_PLAYERS=4,
//   TIMEOUT_CYCLES=8. A table of per-cycle {inputs, expected outputs} records
//   is applied first, followed by hand-written sequences for a full game,
//   idle timeouts and reset out of DONE.
module tb_game_stage_ctrl;

    localparam int NS = 5;
    localparam int NP = 4;
    localparam int TO = 8;

    logic       clk;
    logic       reset;
    logic       start;
    logic       act_valid;
    logic       act_fold;
    logic       reset_game;
    logic [2:0] stage;
    logic [1:0] turn;
    logic [3:0] active_mask;
    logic       stage_adv;
    logic       timeout_fold;
    logic       game_over;
    logic       winner_valid;
    logic [1:0] winner;

    game_stage_ctrl #(
        .NUM_STAGES     (NS),
        .NUM_PLAYERS    (NP),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .act_valid    (act_valid),
        .act_fold     (act_fold),
        .reset_game   (reset_game),
        .stage        (stage),
        .turn         (turn),
        .active_mask  (active_mask),
        .stage_adv    (stage_adv),
        .timeout_fold (timeout_fold),
        .game_over    (game_over),
        .winner_valid (winner_valid),
        .winner       (winner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       rst;
        logic       st;
        logic       av;
        logic       af;
        logic       rg;
        logic [2:0] e_stage;
        logic [1:0] e_turn;
        logic [3:0] e_mask;
        logic       e_adv;
        logic       e_tf;
        logic       e_go;
        logic       e_wv;
        logic [1:0] e_win;
        logic       ck_turn;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic exp_all(input string tag, input logic [2:0] e_stage, input logic [1:0] e_turn,
                           input logic [3:0] e_mask, input logic e_adv, input logic e_tf,
                           input logic e_go, input logic e_wv, input logic [1:0] e_win,
                           input logic ck_turn);
        chk({tag, " stage"}, 32'(stage), 32'(e_stage));
        if (ck_turn) chk({tag, " turn"}, 32'(turn), 32'(e_turn));
        chk({tag, " active_mask"}, 32'(active_mask), 32'(e_mask));
        chk({tag, " stage_adv"}, 32'(stage_adv), 32'(e_adv));
        chk({tag, " timeout_fold"}, 32'(timeout_fold), 32'(e_tf));
        chk({tag, " game_over"}, 32'(game_over), 32'(e_go));
        chk({tag, " winner_valid"}, 32'(winner_valid), 32'(e_wv));
        chk({tag, " winner"}, 32'(winner), 32'(e_win));
    endtask

    // Drive inputs for one cycle, then sample 1 time unit after the edge.
    task automatic step(input logic r, input logic s, input logic av, input logic af, input logic rg);
        reset      = r;
        start      = s;
        act_valid  = av;
        act_fold   = af;
        reset_game = rg;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int adv_count;
        int tf_count;

        reset      = 1'b1;
        start      = 1'b0;
        act_valid  = 1'b0;
        act_fold   = 1'b0;
        reset_game = 1'b0;

        //            rst st av af rg  stage turn mask  adv tf go wv win ckturn
        vecs[0]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 3'd0,2'd0,4'hF, 1'b0,1'b0,1'b0,1'b0,2'd0, 1'b1}; // reset
        vecs[1]  = '{1'b0,1'b1,1'b0,1'b0,1'b0, 3'd1,2'd0,4'hF, 1'b0,1'b0,1'b0,1'b0,2'd0, 1'b1}; // start
        vecs[2]  = '{1'b0,1'b0,1'b1,1'b1,1'b0, 3'd1,2'd1,4'hE, 1'b0,1'b0,1'b0,1'b0,2'd0, 1'b1}; // seat0 folds
        vecs[3]  = '{1'b0,1'b0,1'b1,1'b1,1'b0, 3'd1,2'd2,4'hC, 1'b0,1'b0,1'b0,1'b0,2'd0, 1'b1}; // seat1 folds
        vecs[4]  = '{1'b0,1'b0,1'b1,1'b1,1'b0, 3'd1,2'd0,4'h8, 1'b0,1'b0,1'b1,1'b1,2'd3, 1'b0}; // seat2 folds -> winner 3
        vecs[5]  = '{1'b0,1'b1,1'b1,1'b1,1'b0, 3'd1,2'd0,4'h8, 1'b0,1'b0,1'b1,1'b1,2'd3, 1'b0}; // DONE holds
        vecs[6]  = '{1'b0,1'b0,1'b0,1'b0,1'b1, 3'd0,2'd0,4'hF, 1'b0,1'b0,1'b0,1'b0,2'd0, 1'b1}; // reset_game
        vecs[7]  = '{1'b0,1'b0,1'b1,1'b1,1'b0, 3'd0,2'd0,4'hF, 1'b0,1'b0,1'b0,1'b0,2'd0, 1'b1}; // act ignored in IDLE
        vecs[8]  = '{1'b0,1'b1,1'b0,1'b0,1'b0, 3'd1,2'd0,4'hF, 1'b0,1'b0,1'b0,1'b0,2'd0, 1'b1}; // start
        vecs[9]  = '{1'b0,1'b0,1'b1,1'b0,1'b0, 3'd1,2'd1,4'hF, 1'b0,1'b0,1'b0,1'b0,2'd0, 1'b1}; // seat0 acts
        vecs[10] = '{1'b0,1'b0,1'b1,1'b1,1'b0, 3'd1,2'd2,4'hD, 1'b0,1'b0,1'b0,1'b0,2'd0, 1'b1}; // seat1 folds
        vecs[11] = '{1'b0,1'b1,1'b1,1'b0,1'b0, 3'd1,2'd3,4'hD, 1'b0,1'b0,1'b0,1'b0,2'd0, 1'b1}; // seat2 acts, start ignored
        vecs[12] = '{1'b0,1'b0,1'b1,1'b0,1'b0, 3'd2,2'd0,4'hD, 1'b1,1'b0,1'b0,1'b0,2'd0, 1'b1}; // seat3 -> stage 2
        vecs[13] = '{1'b0,1'b0,1'b1,1'b0,1'b0, 3'd2,2'd2,4'hD, 1'b0,1'b0,1'b0,1'b0,2'd0, 1'b1}; // seat0 -> skip 1
        vecs[14] = '{1'b0,1'b0,1'b1,1'b0,1'b0, 3'd2,2'd3,4'hD, 1'b0,1'b0,1'b0,1'b0,2'd0, 1'b1}; // seat2 acts
        vecs[15] = '{1'b0,1'b0,1'b1,1'b0,1'b0, 3'd3,2'd0,4'hD, 1'b1,1'b0,1'b0,1'b0,2'd0, 1'b1}; // seat3 -> stage 3
        vecs[16] = '{1'b0,1'b0,1'b1,1'b0,1'b1, 3'd0,2'd0,4'hF, 1'b0,1'b0,1'b0,1'b0,2'd0, 1'b1}; // reset_game beats act
        vecs[17] = '{1'b0,1'b1,1'b0,1'b0,1'b1, 3'd0,2'd0,4'hF, 1'b0,1'b0,1'b0,1'b0,2'd0, 1'b1}; // reset_game beats start
        vecs[18] = '{1'b0,1'b1,1'b0,1'b0,1'b0, 3'd1,2'd0,4'hF, 1'b0,1'b0,1'b0,1'b0,2'd0, 1'b1}; // start

        for (int i = 0; i < NV; i++) begin
            step(vecs[i].rst, vecs[i].st, vecs[i].av, vecs[i].af, vecs[i].rg);
            exp_all($sformatf("vec%0d", i), vecs[i].e_stage, vecs[i].e_turn, vecs[i].e_mask,
                    vecs[i].e_adv, vecs[i].e_tf, vecs[i].e_go, vecs[i].e_wv, vecs[i].e_win,
                    vecs[i].ck_turn);
        end

        // Full game: every seat checks in every stage.
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        exp_all("full start", 3'd1, 2'd0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
        adv_count = 0;
        for (int s = 1; s <= NS; s++) begin
            for (int p = 0; p < NP; p++) begin
                step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
                if (stage_adv) adv_count++;
                if (p < NP - 1) begin
                    exp_all($sformatf("full s%0d p%0d", s, p), 3'(s), 2'(p + 1), 4'hF,
                            1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
                end else if (s < NS) begin
                    exp_all($sformatf("full s%0d end", s), 3'(s + 1), 2'd0, 4'hF,
                            1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
                end else begin
                    exp_all("full done", 3'd5, 2'd0, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
                end
            end
        end
        chk("full stage_adv count", 32'(adv_count), 32'd4);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        exp_all("full done hold", 3'd5, 2'd0, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0);

        // Idle timeout at seat 0: the eighth idle cycle auto-folds.
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int c = 1; c < TO; c++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            exp_all($sformatf("to idle%0d", c), 3'd1, 2'd0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_all("to fire", 3'd1, 2'd1, 4'hE, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1);
        tf_count = 0;
        for (int c = 0; c < 3; c++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            if (timeout_fold) tf_count++;
        end
        chk("to single pulse", 32'(tf_count), 32'd0);

        // Action on the eighth cycle wins over the timeout and clears the timer.
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int c = 1; c < TO; c++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        exp_all("to act wins", 3'd1, 2'd1, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
        for (int c = 1; c < TO; c++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            exp_all($sformatf("to re-idle%0d", c), 3'd1, 2'd1, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_all("to fire seat1", 3'd1, 2'd2, 4'hD, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1);

        // Reset out of DONE, with start held to show reset priority.
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        exp_all("rst pre done", 3'd1, 2'd0, 4'h8, 1'b0, 1'b0, 1'b1, 1'b1, 2'd3, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        exp_all("rst from done", 3'd0, 2'd0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        exp_all("rst restart", 3'd1, 2'd0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/game_stage_ctrl.md
GAME_STAGE_CTRL -- requirements
Module: game_stage_ctrl

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 5, number of betting stages per game (2..8).
REQ-002 SHALL have parameter NUM_PLAYERS, default 4, number of seats (2..16).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1000, cycles a player may idle before auto-fold (>=2).
REQ-004 SHALL have: clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have: reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have: start  input  1  begin a game; honoured only in IDLE.
REQ-007 SHALL have: act_valid  input  1  current-turn player has acted this cycle; honoured only in PLAY.
REQ-008 SHALL have: act_fold  input  1  qualifies act_valid; 1 = fold, 0 = check/bet.
REQ-009 SHALL have: reset_game  input  1  abort game, return to IDLE.
REQ-010 SHALL have: stage  output  SW=$clog2(NUM_STAGES+1)  current stage, 0 = no game.
REQ-011 SHALL have: turn  output  TW=max(1,$clog2(NUM_PLAYERS))  seat index to act.
REQ-012 SHALL have: active_mask  output  NUM_PLAYERS  1 = seat still in hand.
REQ-013 SHALL have: stage_adv  output  1  one-cycle pulse on stage increment.
REQ-014 SHALL have: timeout_fold  output  1  one-cycle pulse when a seat is auto-folded.
REQ-015 SHALL have: game_over  output  1  high while in DONE.
REQ-016 SHALL have: winner_valid  output  1  game ended with exactly one active seat.
REQ-017 SHALL have: winner  output  TW  index of sole remaining seat; valid with winner_valid.

Function
REQ-018 SHALL implement states IDLE, PLAY, DONE; all outputs registered.
REQ-019 SHALL, in IDLE with start=1, enter PLAY next cycle with stage=1, turn=0, active_mask=all ones, acted_mask=0, timer=0.
REQ-020 SHALL, in PLAY with act_valid=1, mark seat turn in internal acted_mask, clear its active_mask bit if act_fold=1, clear timer.
REQ-021 SHALL, in PLAY without act_valid, increment timer; at timer==TIMEOUT_CYCLES-1 treat as act_valid with act_fold=1, pulse timeout_fold next cycle, clear timer.
REQ-022 SHALL give act_valid priority over a coincident timeout: no timeout_fold, timer cleared.
REQ-023 SHALL, after a non-completing action, set turn to the next seat above turn (mod NUM_PLAYERS, wrap-around) that is active and not yet acted, effective next cycle.
REQ-024 SHALL complete a stage when every active seat (post-update) is marked in acted_mask.
REQ-025 SHALL, on stage completion with stage<NUM_STAGES, increment stage, clear acted_mask, set turn to lowest-index active seat, pulse stage_adv, all in the same next cycle.
REQ-026 SHALL, on completion of stage NUM_STAGES with >=2 active seats, enter DONE with stage unchanged, winner_valid=0, no stage_adv.
REQ-027 SHALL, whenever an action leaves exactly one active seat, enter DONE next cycle with winner_valid=1, winner=that seat, stage unchanged, no stage_adv, regardless of acted_mask.
REQ-028 SHALL hold all outputs in DONE until reset_game or reset; act_valid, start and timeout ignored in IDLE and DONE; start ignored in PLAY.
REQ-029 SHALL, on reset_game in any state, enter IDLE next cycle with reset values of REQ-031; reset_game overrides start, act_valid and timeout in the same cycle.
REQ-030 SHALL keep timer width $clog2(TIMEOUT_CYCLES); no overflow since it clears at terminal count.

Reset
REQ-031 SHALL, on reset=1, set next cycle: state IDLE, stage=0, turn=0, active_mask=all ones, acted_mask=0, timer=0, stage_adv=0, timeout_fold=0, game_over=0, winner_valid=0, winner=0.
REQ-032 SHALL give reset priority over every other input, including mid-game and in DONE.

Verification (defaults NUM_STAGES=5, NUM_PLAYERS=4, TIMEOUT_CYCLES=8 in bench)
REQ-033 SHALL verify: start, then 4 non-fold acts per stage x5 -> stage 1..5, stage_adv 4 pulses, then game_over=1, winner_valid=0, stage=5.
REQ-034 SHALL verify: stage 1, seats 0,1,2 fold in turn -> DONE after third fold, winner_valid=1, winner=3, stage=1.
REQ-035 SHALL verify: seat 1 folded, stage 2 begins -> turn=0; seat 0 acts -> turn=2 (skip 1); seat 3 acts last -> wrap, stage=3, turn=0.
REQ-036 SHALL verify: no act for 8 cycles at turn=0 -> timeout_fold pulses once, active_mask=4'b1110, turn=1; act_valid on cycle 8 instead -> no timeout_fold.
REQ-037 SHALL verify: reset_game asserted together with act_valid at stage 3 -> next cycle IDLE, stage=0, active_mask=4'b1111, no stage_adv.
REQ-038 SHALL verify: reset during DONE -> next cycle all outputs at REQ-031 values; new start begins stage 1.
